// File: rtl/sram_cmd_ctrl_pkg.sv
// Shared definitions for the serial SRAM command controller:
// command codes, FSM state encoding and the default CONST reply.
package sram_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_INC = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;

  localparam logic [31:0] CONST_VAL_DEFAULT = 32'd259;
  localparam logic [31:0] RESP_UNKNOWN      = 32'hFFFF_FFFF;
  localparam logic [31:0] RESP_WRITE_DONE   = 32'h0000_0003;

  typedef enum logic [2:0] {
    ST_RX       = 3'd0,
    ST_EXEC     = 3'd1,
    ST_RAM_REQ  = 3'd2,
    ST_RAM_WAIT = 3'd3,
    ST_TX_SEND  = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  function automatic logic is_ram_cmd(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ) || (c == CMD_READ_INC);
  endfunction

endpackage

// File: rtl/sram_cmd_framer.sv
// Assembles cmd + 4 big-endian data bytes into one frame; a partial frame is
// dropped after TIMEOUT idle cycles. frame_valid pulses one cycle after byte 5.
module sram_cmd_framer #(
  parameter int TIMEOUT = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic [31:0] data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  logic [39:0]   shreg;
  logic [2:0]    count;
  logic [TW-1:0] idle_cnt;
  logic          expired;

  assign expired = (count != 3'd0) && (idle_cnt >= TMO);
  assign cmd     = shreg[39:32];
  assign data    = shreg[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      count       <= 3'd0;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (enable) begin
        if (rx_valid) begin
          shreg    <= {shreg[31:0], rx_data};
          idle_cnt <= '0;
          // A byte landing on the timeout cycle starts a fresh frame.
          if (expired) begin
            count <= 3'd1;
          end else if (count == 3'd4) begin
            count       <= 3'd0;
            frame_valid <= 1'b1;
          end else begin
            count <= count + 3'd1;
          end
        end else if (expired) begin
          count    <= 3'd0;
          idle_cnt <= '0;
        end else if (count != 3'd0) begin
          idle_cnt <= idle_cnt + T_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/sram_cmd_ctrl.sv
// Serial command controller: 5-byte frames in, SRAM access via ready/start, 4-byte reply out.
// Reply starts >=2 cycles after the 5th byte; stalls on ram_ready/tx_ready; bytes received while busy are dropped.
module sram_cmd_ctrl
  import sram_cmd_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter int          TIMEOUT    = 1200000,
  parameter logic [31:0] CONST_VAL  = CONST_VAL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  input  logic                  ram_ready,
  output logic                  ram_start,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_write,
  input  logic [7:0]            ram_data_read,
  output logic                  busy,
  output logic                  rx_overrun
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t      state, state_nxt;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic [31:0] resp;
  logic [31:0] frame_cnt;
  logic [1:0]  byte_cnt;
  logic        wait_armed;
  logic        tx_fell;

  sram_cmd_framer #(
    .TIMEOUT (TIMEOUT)
  ) u_framer (
    .clk         (clk),
    .reset       (reset),
    .enable      ((state == ST_RX) && !frame_valid),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .frame_valid (frame_valid),
    .cmd         (cmd),
    .data        (data)
  );

  assign busy    = (state != ST_RX);
  assign tx_data = resp[31:24];

  always_comb begin
    state_nxt = state;
    ram_start = 1'b0;
    tx_start  = 1'b0;
    case (state)
      ST_RX: begin
        if (frame_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = is_ram_cmd(cmd) ? ST_RAM_REQ : ST_TX_SEND;
      end
      ST_RAM_REQ: begin
        if (ram_ready) begin
          ram_start = 1'b1;
          state_nxt = ST_RAM_WAIT;
        end
      end
      ST_RAM_WAIT: begin
        // The driver may still show ready in the cycle right after start.
        if (wait_armed && ram_ready) state_nxt = ST_TX_SEND;
      end
      ST_TX_SEND: begin
        if (tx_ready) begin
          tx_start  = 1'b1;
          state_nxt = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (tx_fell && tx_ready) state_nxt = (byte_cnt == 2'd3) ? ST_RX : ST_TX_SEND;
      end
      default: state_nxt = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RX;
      resp           <= '0;
      frame_cnt      <= '0;
      byte_cnt       <= 2'd0;
      wait_armed     <= 1'b0;
      tx_fell        <= 1'b0;
      ram_re         <= 1'b0;
      ram_address    <= '0;
      ram_data_write <= '0;
      rx_overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rx_valid && ((state != ST_RX) || frame_valid)) rx_overrun <= 1'b1;

      case (state)
        ST_EXEC: begin
          byte_cnt <= 2'd0;
          case (cmd)
            CMD_ADDR: begin
              ram_address <= data[ADDR_WIDTH-1:0];
              resp        <= data;
            end
            CMD_LOAD: begin
              ram_data_write <= data[7:0];
              resp           <= data;
            end
            CMD_WRITE:              ram_re <= 1'b0;
            CMD_READ, CMD_READ_INC: ram_re <= 1'b1;
            CMD_COUNT: begin
              resp      <= frame_cnt;
              frame_cnt <= frame_cnt + 32'd1;
            end
            CMD_CONST: resp <= CONST_VAL;
            default:   resp <= RESP_UNKNOWN;
          endcase
        end
        ST_RAM_REQ: wait_armed <= 1'b0;
        ST_RAM_WAIT: begin
          if (!wait_armed) begin
            wait_armed <= 1'b1;
          end else if (ram_ready) begin
            resp <= (cmd == CMD_WRITE) ? RESP_WRITE_DONE : {24'h0, ram_data_read};
            if (cmd == CMD_READ_INC) ram_address <= ram_address + ADDR_ONE;
          end
        end
        ST_TX_SEND: tx_fell <= 1'b0;
        ST_TX_WAIT: begin
          if (!tx_fell) begin
            if (!tx_ready) tx_fell <= 1'b1;
          end else if (tx_ready) begin
            resp     <= {resp[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            tx_fell  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Directed bench for sram_cmd_ctrl with behavioural sram_driver and uart_tx models.
module tb_sram_cmd_ctrl;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          ram_ready;
  logic          ram_start;
  logic          ram_re;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_write;
  logic [7:0]    ram_data_read;
  logic          busy;
  logic          rx_overrun;

  always #5 clk = ~clk;

  sram_cmd_ctrl #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (50),
    .CONST_VAL  (32'd259)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .ram_ready      (ram_ready),
    .ram_start      (ram_start),
    .ram_re         (ram_re),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_data_read  (ram_data_read),
    .busy           (busy),
    .rx_overrun     (rx_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM driver model: ready stays high one cycle after start, then low 4 cycles.
  logic [7:0]    mem [0:8191];
  int            rcnt = 0;
  int            ram_starts = 0;
  logic          acc_re = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [7:0]    acc_wdata = 8'h00;
  int            stab_err = 0;
  int            dbl_ram = 0;
  int            dbl_tx = 0;
  int            overlap_err = 0;
  logic          prev_ram_start = 1'b0;
  logic          prev_tx_start = 1'b0;

  always @(posedge clk) begin
    prev_ram_start <= ram_start;
    prev_tx_start  <= tx_start;
    if (reset) begin
      ram_ready     <= 1'b1;
      ram_data_read <= 8'h00;
      rcnt          <= 0;
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h0123] <= 8'h5A;
      mem[13'h1FFF] <= 8'hC3;
    end else begin
      if (ram_start && prev_ram_start) dbl_ram <= dbl_ram + 1;
      if (tx_start && prev_tx_start) dbl_tx <= dbl_tx + 1;
      if (tx_start && rcnt > 0) overlap_err <= overlap_err + 1;
      if (rcnt > 0 && (ram_re !== acc_re || ram_address !== acc_addr || ram_data_write !== acc_wdata))
        stab_err <= stab_err + 1;
      if (ram_start) begin
        ram_starts <= ram_starts + 1;
        acc_re     <= ram_re;
        acc_addr   <= ram_address;
        acc_wdata  <= ram_data_write;
        if (!ram_re) mem[ram_address] <= ram_data_write;
        rcnt <= 5;
      end else if (rcnt > 0) begin
        rcnt <= rcnt - 1;
        if (rcnt == 5) ram_ready <= 1'b0;
        if (rcnt == 1) begin
          ram_ready <= 1'b1;
          if (acc_re) ram_data_read <= mem[acc_addr];
        end
      end
    end
  end

  // uart_tx model: tx_ready falls two cycles after start, idle again 4 cycles later.
  logic [7:0] txq[$];
  int         tcnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      tx_ready <= 1'b1;
      tcnt     <= 0;
    end else if (tx_start) begin
      txq.push_back(tx_data);
      tcnt <= 6;
    end else if (tcnt > 0) begin
      tcnt <= tcnt - 1;
      if (tcnt == 5) tx_ready <= 1'b0;
      if (tcnt == 1) tx_ready <= 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
    send_byte(c);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic expect_reply(input string tag, input logic [31:0] exp);
    int budget;
    logic [31:0] w;
    budget = 3000;
    while (txq.size() < 4 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (txq.size() < 4) begin
      check({tag, "_timeout"}, txq.size(), 4);
      txq.delete();
      return;
    end
    w = {txq[0], txq[1], txq[2], txq[3]};
    repeat (4) void'(txq.pop_front());
    check(tag, w, exp);
    budget = 200;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy) check({tag, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl"}, {27'b0, tx_start, ram_start, ram_re, busy, rx_overrun}, 32'h0);
    check({tag, "_data"}, {16'b0, tx_data, ram_data_write}, 32'h0);
    check({tag, "_addr"}, {19'b0, ram_address}, 32'h0);
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ADDR then READ
    send_frame(8'h01, 32'h0000_0123);
    expect_reply("addr_reply", 32'h0000_0123);
    check("addr_reg", {19'b0, ram_address}, 32'h123);
    send_frame(8'h04, 32'h0);
    expect_reply("read_reply", 32'h0000_005A);
    check("read_starts", ram_starts, 1);
    check("read_re_addr", {18'b0, acc_re, acc_addr}, {18'b0, 1'b1, 13'h0123});

    // LOAD then WRITE
    send_frame(8'h02, 32'h0000_00A5);
    expect_reply("load_reply", 32'h0000_00A5);
    check("load_reg", {24'b0, ram_data_write}, 32'hA5);
    send_frame(8'h03, 32'h0);
    expect_reply("write_reply", 32'h0000_0003);
    check("write_starts", ram_starts, 2);
    check("write_acc", {10'b0, acc_re, acc_addr, acc_wdata}, {10'b0, 1'b0, 13'h0123, 8'hA5});
    check("write_mem", {24'b0, mem[13'h0123]}, 32'hA5);

    // READ_INC at the top address wraps to 0
    send_frame(8'h01, 32'h0000_1FFF);
    expect_reply("addr_top_reply", 32'h0000_1FFF);
    send_frame(8'h05, 32'h0);
    expect_reply("readinc_reply", 32'h0000_00C3);
    check("readinc_wrap", {19'b0, ram_address}, 32'h0);
    check("readinc_starts", ram_starts, 3);

    // COUNT, unknown, CONST
    send_frame(8'h06, 32'h0);
    expect_reply("count0", 32'h0);
    send_frame(8'h06, 32'h0);
    expect_reply("count1", 32'h1);
    send_frame(8'h06, 32'h0);
    expect_reply("count2", 32'h2);
    send_frame(8'h9C, 32'h1234_5678);
    expect_reply("unknown_reply", 32'hFFFF_FFFF);
    check("unknown_addr", {19'b0, ram_address}, 32'h0);
    send_frame(8'h06, 32'h0);
    expect_reply("count3", 32'h3);
    send_frame(8'h07, 32'h0);
    expect_reply("const_reply", 32'h0000_0103);

    // Partial frame discarded after idle timeout
    send_byte(8'h06);
    send_byte(8'h06);
    repeat (60) @(negedge clk);
    send_frame(8'h07, 32'h0);
    expect_reply("timeout_const", 32'h0000_0103);
    repeat (20) @(negedge clk);
    check("timeout_extra_tx", txq.size(), 0);
    check("no_overrun_yet", {31'b0, rx_overrun}, 32'h0);

    // Byte during TX_WAIT sets overrun and leaves the reply intact
    send_frame(8'h07, 32'h0);
    budget = 500;
    while (txq.size() < 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    check("overrun_set", {31'b0, rx_overrun}, 32'h1);
    expect_reply("overrun_const", 32'h0000_0103);
    send_frame(8'h06, 32'h0);
    expect_reply("count4", 32'h4);

    // Reset during RAM_WAIT
    send_frame(8'h01, 32'h0000_0123);
    expect_reply("addr2_reply", 32'h0000_0123);
    send_frame(8'h04, 32'h0);
    budget = 500;
    while (rcnt == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("ramwait_reached", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("rst_ramwait");
    repeat (20) @(negedge clk);
    check("rst_ramwait_tx", txq.size(), 0);
    send_frame(8'h01, 32'h0000_0042);
    expect_reply("post_rst1_addr", 32'h0000_0042);

    // Reset during the second TX byte
    send_frame(8'h07, 32'h0);
    budget = 500;
    while (txq.size() < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("rst_tx");
    repeat (30) @(negedge clk);
    check("rst_tx_bytes", txq.size(), 2);
    txq.delete();
    send_frame(8'h01, 32'h0000_0077);
    expect_reply("post_rst2_addr", 32'h0000_0077);
    check("post_rst2_reg", {19'b0, ram_address}, 32'h77);
    send_frame(8'h06, 32'h0);
    expect_reply("post_rst2_count", 32'h0);

    check("dbl_ram_start", dbl_ram, 0);
    check("dbl_tx_start", dbl_tx, 0);
    check("ram_stability", stab_err, 0);
    check("tx_during_access", overlap_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
